// File: rtl/ram_pkg.sv
// Shared definitions for the single-clock simple-dual-port RAM family:
// collision-mode encodings and the clear engine state type.
package ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_sdp_clr_if.sv
// User-side port bundle of ram_sdp_clr: clear request, write port, read port.
// The master modport is the client, the slave modport is the RAM.
interface ram_sdp_clr_if #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
);

  localparam int unsigned BE_WIDTH = D_WIDTH / 8;

  logic                clear_req;
  logic                busy;
  logic                write_enable;
  logic [A_WIDTH-1:0]  address_write;
  logic [D_WIDTH-1:0]  data_write;
  logic [BE_WIDTH-1:0] byte_enable;
  logic                read_enable;
  logic [A_WIDTH-1:0]  address_read;
  logic [D_WIDTH-1:0]  data_read;
  logic                read_valid;

  modport master (
    output clear_req,
    output write_enable,
    output address_write,
    output data_write,
    output byte_enable,
    output read_enable,
    output address_read,
    input  busy,
    input  data_read,
    input  read_valid
  );

  modport slave (
    input  clear_req,
    input  write_enable,
    input  address_write,
    input  data_write,
    input  byte_enable,
    input  read_enable,
    input  address_read,
    output busy,
    output data_read,
    output read_valid
  );

endinterface

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address once writing zero, reporting busy while active.
// Supplies the clear address/strobe that the top-level write mux gives priority to.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int unsigned A_WIDTH        = 5,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_req,
  output logic               busy,
  output logic               clr_we_c,
  output logic [A_WIDTH-1:0] clr_addr_c
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;
  localparam clr_state_e  RST_STATE = (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;

  clr_state_e         state;
  logic [A_WIDTH-1:0] cnt;

  // busy mirrors the state so it is available straight from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clear_req) begin
            state <= CLR_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLR_RUN: begin
          cnt <= cnt + A_WIDTH'(1);
          if (cnt == A_WIDTH'(DEPTH - 1)) begin
            state <= CLR_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CLR_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Held reset must not leave the array being rewritten at the parked address
  assign clr_we_c   = (state == CLR_RUN) && !reset;
  assign clr_addr_c = cnt;

endmodule

// File: rtl/ram_sdp_clr.sv
// Single-clock simple-dual-port RAM with byte-lane writes, selectable read
// latency and read-during-write mode, plus a built-in full-array clear engine.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int unsigned D_WIDTH        = 16,
  parameter int unsigned A_WIDTH        = 5,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           reset,
  ram_sdp_clr_if.slave  bus
);

  localparam int unsigned DEPTH    = 2 ** A_WIDTH;
  localparam int unsigned BE_WIDTH = D_WIDTH / 8;

  generate
    if ((D_WIDTH % 8) != 0) begin : g_bad_width
      $error("ram_sdp_clr: D_WIDTH must be a multiple of 8");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
      $error("ram_sdp_clr: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic               busy;
  logic               clr_we_c;
  logic [A_WIDTH-1:0] clr_addr_c;

  ram_clear_fsm #(
    .A_WIDTH        (A_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (bus.clear_req),
    .busy       (busy),
    .clr_we_c   (clr_we_c),
    .clr_addr_c (clr_addr_c)
  );

  assign bus.busy = busy;

  logic wr_acc_c;
  logic rd_acc_c;

  assign wr_acc_c = bus.write_enable && !busy && !reset;
  assign rd_acc_c = bus.read_enable  && !busy && !reset;

  logic [D_WIDTH-1:0] wr_old_c;
  logic [D_WIDTH-1:0] wr_merged_c;
  logic [D_WIDTH-1:0] rd_word_c;

  assign wr_old_c = mem[bus.address_write];

  // Byte-lane merge: disabled lanes keep the stored value
  always_comb begin
    wr_merged_c = wr_old_c;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (bus.byte_enable[i]) begin
        wr_merged_c[8*i +: 8] = bus.data_write[8*i +: 8];
      end
    end
  end

  // Write-first collisions forward the merged word; read-first sees the old array value
  always_comb begin
    rd_word_c = mem[bus.address_read];
    if ((RDW_MODE == RDW_WRITE_FIRST) && wr_acc_c &&
        (bus.address_write == bus.address_read)) begin
      rd_word_c = wr_merged_c;
    end
  end

  // Array has no reset; the clear engine owns the port while busy
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_addr_c] <= '0;
    end else if (wr_acc_c) begin
      mem[bus.address_write] <= wr_merged_c;
    end
  end

  logic               s1_vld;
  logic [D_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_acc_c;
      if (rd_acc_c) begin
        s1_data <= rd_word_c;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic               s2_vld;
      logic [D_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
          end
        end
      end

      assign bus.data_read  = s2_data;
      assign bus.read_valid = s2_vld;
    end else begin : g_lat1
      assign bus.data_read  = s1_data;
      assign bus.read_valid = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (read-first/latency 1 and write-first/latency 2)
// share one stimulus stream and are checked every cycle against an array model.
module tb_ram_sdp_clr;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          clear_req;
  logic          we;
  logic          re;
  logic [AW-1:0] aw;
  logic [AW-1:0] ar;
  logic [DW-1:0] wd;
  logic [1:0]    be;

  ram_sdp_clr_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus0 ();
  ram_sdp_clr_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus1 ();

  assign bus0.clear_req     = clear_req;
  assign bus0.write_enable  = we;
  assign bus0.address_write = aw;
  assign bus0.data_write    = wd;
  assign bus0.byte_enable   = be;
  assign bus0.read_enable   = re;
  assign bus0.address_read  = ar;

  assign bus1.clear_req     = clear_req;
  assign bus1.write_enable  = we;
  assign bus1.address_write = aw;
  assign bus1.data_write    = wd;
  assign bus1.byte_enable   = be;
  assign bus1.read_enable   = re;
  assign bus1.address_read  = ar;

  ram_sdp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  ram_sdp_clr #(.D_WIDTH(DW), .A_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Reference model state
  logic [DW-1:0] model [DEPTH];
  int            clr_left;
  int            clr_ptr;
  logic          e0_v;
  logic [DW-1:0] e0_d;
  logic          e1_v;
  logic [DW-1:0] e1_d;
  logic          p1_v;
  logic [DW-1:0] p1_d;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [1:0] b);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 2; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic idle_in();
    we = 1'b0; re = 1'b0; clear_req = 1'b0;
  endtask

  // One clock edge: predict, advance, then compare all outputs of both instances
  task automatic cycle();
    logic          busy_now, wa, ra;
    logic [DW-1:0] merged, rf, wf;
    busy_now = (clr_left > 0);
    wa       = we && !busy_now;
    ra       = re && !busy_now;
    merged   = merge(model[aw], wd, be);
    rf       = model[ar];
    wf       = (wa && (aw == ar)) ? merged : rf;
    @(posedge clk);
    if (busy_now) begin
      model[clr_ptr] = '0;
      clr_ptr++;
      clr_left--;
    end else begin
      if (wa) model[aw] = merged;
      if (clear_req) begin
        clr_left = DEPTH;
        clr_ptr  = 0;
      end
    end
    e1_v = p1_v;
    if (p1_v) e1_d = p1_d;
    p1_v = ra;
    if (ra) p1_d = wf;
    e0_v = ra;
    if (ra) e0_d = rf;
    #1;
    chk("busy0",  32'(bus0.busy),       32'(clr_left > 0));
    chk("busy1",  32'(bus1.busy),       32'(clr_left > 0));
    chk("valid0", 32'(bus0.read_valid), 32'(e0_v));
    chk("data0",  32'(bus0.data_read),  32'(e0_d));
    chk("valid1", 32'(bus1.read_valid), 32'(e1_v));
    chk("data1",  32'(bus1.data_read),  32'(e1_d));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    e0_v = 1'b0; e0_d = '0; e1_v = 1'b0; e1_d = '0; p1_v = 1'b0; p1_d = '0;
    clr_left = DEPTH;
    clr_ptr  = 0;
    chk("rst_valid0", 32'(bus0.read_valid), 32'd0);
    chk("rst_data0",  32'(bus0.data_read),  32'd0);
    chk("rst_valid1", 32'(bus1.read_valid), 32'd0);
    chk("rst_data1",  32'(bus1.data_read),  32'd0);
    chk("rst_busy0",  32'(bus0.busy),       32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while ((bus0.busy === 1'b1) && (n < 40)) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [1:0] b);
    we = 1'b1; aw = AW'(a); wd = d; be = b;
    cycle();
    we = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    re = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ar = AW'(i);
      cycle();
      chk(tag, 32'(bus0.data_read), 32'd0);
    end
    re = 1'b0;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_in();
    aw = '0; ar = '0; wd = '0; be = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #2;

    // Power-on clear and zero readback
    apply_reset();
    wait_clear("clr_len_por");
    read_all_zero("por_zero");

    // Byte-lane merge
    do_write(3, 16'hABCD, 2'b11);
    do_write(3, 16'h1200, 2'b10);
    re = 1'b1; ar = AW'(3);
    cycle();
    re = 1'b0;
    chk("be_valid0", 32'(bus0.read_valid), 32'd1);
    chk("be_merge0", 32'(bus0.data_read), 32'h12CD);
    cycle();
    chk("be_merge1", 32'(bus1.data_read), 32'h12CD);

    // Read-during-write collision
    do_write(7, 16'h1111, 2'b11);
    we = 1'b1; aw = AW'(7); wd = 16'h2222; be = 2'b11; re = 1'b1; ar = AW'(7);
    cycle();
    idle_in();
    chk("rdw_read_first", 32'(bus0.data_read), 32'h1111);
    chk("rdw_lat2_wait", 32'(bus1.read_valid), 32'd0);
    cycle();
    chk("rdw_write_first", 32'(bus1.data_read), 32'h2222);

    // Back-to-back reads through the 2-cycle pipeline
    for (int i = 0; i < 3; i++) do_write(i, DW'(16'h00A0 + i), 2'b11);
    re = 1'b1;
    ar = AW'(0); cycle();
    chk("lat2_first", 32'(bus1.read_valid), 32'd0);
    ar = AW'(1); cycle();
    chk("lat2_v0", 32'(bus1.read_valid), 32'd1);
    chk("lat2_d0", 32'(bus1.data_read), 32'h00A0);
    ar = AW'(2); cycle();
    re = 1'b0;
    chk("lat2_v1", 32'(bus1.read_valid), 32'd1);
    chk("lat2_d1", 32'(bus1.data_read), 32'h00A1);
    cycle();
    chk("lat2_v2", 32'(bus1.read_valid), 32'd1);
    chk("lat2_d2", 32'(bus1.data_read), 32'h00A2);
    cycle();
    chk("lat2_end", 32'(bus1.read_valid), 32'd0);

    // Clear request with traffic before and during busy
    for (int i = 0; i < DEPTH; i++) do_write(i, 16'h5A5A, 2'b11);
    clear_req = 1'b1;
    we = 1'b1; aw = AW'(5); wd = 16'h7777; be = 2'b11;
    re = 1'b1; ar = AW'(4);
    cycle();
    chk("pre_busy_read", 32'(bus0.data_read), 32'h5A5A);
    begin
      int n;
      n = 0;
      while ((bus0.busy === 1'b1) && (n < 40)) begin
        we = 1'b1; aw = AW'($urandom_range(0, DEPTH - 1)); wd = DW'($urandom);
        be = 2'($urandom);
        re = 1'b1; ar = AW'($urandom_range(0, DEPTH - 1));
        clear_req = 1'($urandom);
        cycle();
        n++;
        chk("busy_no_valid", 32'(bus0.read_valid), 32'd0);
      end
      chk("clr_len_req", 32'(n), 32'd32);
    end
    idle_in();
    read_all_zero("req_zero");

    // Reset ten cycles into a clear restarts it from address 0
    for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom) | DW'(1), 2'b11);
    re = 1'b1; ar = AW'(9);
    cycle();
    idle_in();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (10) cycle();
    apply_reset();
    wait_clear("clr_len_abort");
    read_all_zero("abort_zero");

    // Randomized mixed traffic
    for (int k = 0; k < 400; k++) begin
      int span;
      span = ($urandom_range(0, 1) == 0) ? 7 : DEPTH - 1;
      we = 1'($urandom); aw = AW'($urandom_range(0, span)); wd = DW'($urandom);
      be = 2'($urandom);
      re = 1'($urandom); ar = AW'($urandom_range(0, span));
      clear_req = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle_in();
    repeat (40) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
